// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch unit.
// Imported by fetch_ctrl and fetch_fifo.
package fetch_pkg;

  typedef enum logic {
    S_REQ,
    S_WAIT
  } fetch_state_e;

  localparam int PC_INC      = 4;
  localparam int DEF_PC_W    = 8;
  localparam int DEF_INSTR_W = 32;

  typedef struct packed {
    logic [DEF_PC_W-1:0]    pc;
    logic [DEF_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// First-word fall-through sync FIFO with flush.
// Push and pop may coincide at any fill level.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 40
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && !flush
                && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q
              + (AW+1)'(do_push)
              - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // Credit accounting upstream must make this impossible.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !(push && full && !pop)
  );

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, runs the
// imem handshake and buffers results toward decode.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              PC_W       = 8,
  parameter int              INSTR_W    = 32,
  parameter int              FIFO_DEPTH = 2,
  parameter logic [PC_W-1:0] RESET_PC   = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_addr,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = PC_W + INSTR_W;

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   inflight_pc_q, inflight_pc_d;
  logic              drop_q, drop_d;

  logic              push, pop, flush;
  logic              inflight, has_credit;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;
  logic [ENT_W-1:0]  push_data, pop_data;

  assign inflight   = (state_q == S_WAIT);
  assign has_credit =
    (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;

  assign imem_addr = pc_q;
  assign push_data = {inflight_pc_q, imem_rdata};
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign out_pc    = pop_data[ENT_W-1 -: PC_W];
  assign out_instr = pop_data[INSTR_W-1:0];

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    drop_d        = drop_q;
    imem_req      = 1'b0;
    push          = 1'b0;
    flush         = 1'b0;
    unique case (state_q)
      S_REQ: begin
        imem_req = has_credit
                && !redirect_valid
                && !rst;
        if (imem_req && imem_gnt) begin
          state_d       = S_WAIT;
          inflight_pc_d = pc_q;
          pc_d          = pc_q + PC_W'(PC_INC);
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_REQ;
          push    = !drop_q && !redirect_valid;
          drop_d  = 1'b0;
        end
      end
      default: state_d = S_REQ;
    endcase
    // Redirect wins: kill buffered work and any
    // response still outstanding after this cycle.
    if (redirect_valid) begin
      pc_d  = redirect_addr;
      flush = 1'b1;
      if (inflight && !imem_rvalid) drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      drop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      drop_q        <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: vector table for
// steady-state fetch plus hand-written corner cases.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_addr = '0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_pc;
  logic [31:0] out_instr;

  int n_tests = 0;
  int n_fail  = 0;

  logic       pend = 1'b0;
  logic [7:0] pend_addr = '0;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .PC_W       (8),
    .INSTR_W    (32),
    .FIFO_DEPTH (2),
    .RESET_PC   (8'h00)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  function automatic logic [31:0] data_of(
    input logic [7:0] a);
    return {8'hC3, a, ~a, 8'h3C};
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // One cycle with a one-deep memory model.
  // Returns at the negedge for output checks.
  task automatic drive(input logic       r,
                       input logic       redir,
                       input logic [7:0] raddr,
                       input logic       rdy,
                       input logic       g_en,
                       input logic       rv_en);
    logic rv;
    @(posedge clk);
    #1;
    rst            = r;
    redirect_valid = redir;
    redirect_addr  = raddr;
    out_ready      = rdy;
    rv             = rv_en && pend;
    imem_rvalid    = rv;
    imem_rdata     = rv ? data_of(pend_addr)
                        : 32'hDEAD_BEEF;
    if (rv) pend = 1'b0;
    #1;
    imem_gnt = g_en && imem_req;
    if (imem_gnt) begin
      pend      = 1'b1;
      pend_addr = imem_addr;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    pend = 1'b0;
    drive(1, 0, 8'h00, 0, 0, 0);
    drive(1, 0, 8'h00, 0, 0, 0);
  endtask

  typedef struct {
    logic       gnt;
    logic       rv;
    logic [7:0] rd_addr;
    logic       rdy;
    logic       e_req;
    logic [7:0] e_addr;
    logic       e_ov;
    logic [7:0] e_pc;
  } vec_t;

  vec_t tbl [10];
  fetch_entry_t exp_ent;

  initial begin
    tbl[0] = '{1, 0, 8'h00, 1, 1, 8'h00, 0, 8'h00};
    tbl[1] = '{0, 1, 8'h00, 1, 0, 8'h04, 0, 8'h00};
    tbl[2] = '{1, 0, 8'h00, 1, 1, 8'h04, 1, 8'h00};
    tbl[3] = '{0, 1, 8'h04, 1, 0, 8'h08, 0, 8'h00};
    tbl[4] = '{1, 0, 8'h00, 1, 1, 8'h08, 1, 8'h04};
    tbl[5] = '{0, 1, 8'h08, 1, 0, 8'h0C, 0, 8'h00};
    tbl[6] = '{0, 0, 8'h00, 1, 1, 8'h0C, 1, 8'h08};
    tbl[7] = '{1, 0, 8'h00, 1, 1, 8'h0C, 0, 8'h00};
    tbl[8] = '{0, 1, 8'h0C, 1, 0, 8'h10, 0, 8'h00};
    tbl[9] = '{0, 0, 8'h00, 1, 1, 8'h10, 1, 8'h0C};

    // Reset state
    do_reset();
    chk("rst_req",   imem_req,  0);
    chk("rst_valid", out_valid, 0);
    chk("rst_addr",  imem_addr, 8'h00);

    // Sequential fetch from the vector table
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      rst            = 1'b0;
      redirect_valid = 1'b0;
      imem_gnt       = tbl[i].gnt;
      imem_rvalid    = tbl[i].rv;
      imem_rdata     = tbl[i].rv
                     ? data_of(tbl[i].rd_addr)
                     : 32'hDEAD_BEEF;
      out_ready      = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d_req", i),
          imem_req, tbl[i].e_req);
      chk($sformatf("v%0d_addr", i),
          imem_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_ov", i),
          out_valid, tbl[i].e_ov);
      if (tbl[i].e_ov) begin
        exp_ent.pc    = tbl[i].e_pc;
        exp_ent.instr = data_of(tbl[i].e_pc);
        chk($sformatf("v%0d_pc", i),
            out_pc, exp_ent.pc);
        chk($sformatf("v%0d_instr", i),
            out_instr, exp_ent.instr);
      end
    end

    // Back-pressure: two entries fill the FIFO
    do_reset();
    drive(0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1, 1);
    chk("bp_ov",   out_valid, 1);
    chk("bp_pc",   out_pc,    8'h00);
    chk("bp_req",  imem_req,  0);
    chk("bp_addr", imem_addr, 8'h08);
    drive(0, 0, 0, 1, 1, 1);
    chk("bp_req_pop", imem_req, 0);
    drive(0, 0, 0, 0, 1, 1);
    chk("bp_pc2",   out_pc,    8'h04);
    chk("bp_req2",  imem_req,  1);
    chk("bp_addr2", imem_addr, 8'h08);

    // PC wrap FC -> 00
    do_reset();
    drive(0, 1, 8'hFC, 1, 1, 1);
    chk("wr_req_redir", imem_req, 0);
    drive(0, 0, 0, 1, 1, 1);
    chk("wr_addr_fc", imem_addr, 8'hFC);
    drive(0, 0, 0, 1, 1, 1);
    chk("wr_addr_00", imem_addr, 8'h00);
    drive(0, 0, 0, 1, 1, 1);
    chk("wr_pc_fc",   out_pc,    8'hFC);
    chk("wr_ins_fc",  out_instr, data_of(8'hFC));
    drive(0, 0, 0, 1, 1, 1);
    drive(0, 0, 0, 1, 1, 1);
    chk("wr_ov_00",   out_valid, 1);
    chk("wr_pc_00",   out_pc,    8'h00);

    // Redirect while waiting on 08
    do_reset();
    drive(0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 1, 1, 1);
    drive(0, 0, 0, 0, 1, 1);
    chk("rd_wait_pc", out_pc, 8'h04);
    drive(0, 1, 8'h40, 0, 1, 0);
    chk("rd_req_redir", imem_req, 0);
    drive(0, 0, 0, 0, 1, 1);
    chk("rd_flush_ov", out_valid, 0);
    chk("rd_drop_req", imem_req,  0);
    chk("rd_addr_40",  imem_addr, 8'h40);
    drive(0, 0, 0, 0, 1, 1);
    chk("rd_req_40", imem_req,  1);
    chk("rd_ov_off", out_valid, 0);
    drive(0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1, 1);
    chk("rd_ov_40",  out_valid, 1);
    chk("rd_pc_40",  out_pc,    8'h40);
    chk("rd_ins_40", out_instr, data_of(8'h40));

    // Redirect coinciding with a response
    do_reset();
    drive(0, 0, 0, 1, 1, 1);
    drive(0, 1, 8'h80, 1, 1, 1);
    chk("rv_req_redir", imem_req, 0);
    drive(0, 0, 0, 1, 1, 1);
    chk("rv_ov",   out_valid, 0);
    chk("rv_req",  imem_req,  1);
    chk("rv_addr", imem_addr, 8'h80);
    drive(0, 0, 0, 1, 1, 1);
    drive(0, 0, 0, 1, 1, 1);
    chk("rv_ov_80",  out_valid, 1);
    chk("rv_pc_80",  out_pc,    8'h80);
    chk("rv_ins_80", out_instr, data_of(8'h80));

    // Reset mid-fetch, then a stale response
    do_reset();
    drive(0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1, 1);
    chk("mr_ov_pre", out_valid, 1);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    chk("mr_ov",   out_valid, 0);
    chk("mr_addr", imem_addr, 8'h00);
    chk("mr_req",  imem_req,  1);
    drive(0, 0, 0, 0, 0, 1);
    chk("mr_stale_ov", out_valid, 0);
    chk("mr_req2",     imem_req,  1);
    chk("mr_addr2",    imem_addr, 8'h00);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the 8-bit-PC core.
- Owns the architectural fetch PC and selects the next PC from three sources: reset vector, jump redirect from execute, or sequential PC+4.
- Drives the instruction-memory request/grant/response handshake and buffers fetched instructions in a small FIFO toward decode.
- Handles stalls (decode back-pressure) and flushes (redirect kills buffered and in-flight fetches).

Parameters:
- PC_W, 8, PC and address width.
- INSTR_W, 32, instruction width.
- FIFO_DEPTH, 2, fetch buffer entries (power of two, >=2).
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- redirect_valid  in  1  jump/branch taken from execute (is_jump).
- redirect_addr  in  PC_W  jump target (jump_addr).
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  PC_W  request address; stable while imem_req && !imem_gnt.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response valid; arrives exactly one response per grant, latency >=1 cycle.
- imem_rdata  in  INSTR_W  response data.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts the instruction.
- out_pc  out  PC_W  PC of the presented instruction.
- out_instr  out  INSTR_W  presented instruction.

Behaviour:
- Reset: pc_q=RESET_PC; state=S_REQ; FIFO empty; drop_q=0; imem_req=0; out_valid=0. imem_req may assert from the first cycle after rst deasserts.
- FSM states:
  - S_REQ: imem_req=1 iff credits>0, where credits = FIFO_DEPTH - fifo_count - inflight.
  - S_WAIT: one request outstanding; imem_req=0.
  - Max one outstanding request.
- S_REQ->S_WAIT on imem_req&&imem_gnt. On this transition: record inflight_pc=pc_q, then pc_q <= pc_q+4, mod 2^PC_W (8'hFC -> 8'h00 wrap, no carry out).
- S_WAIT->S_REQ on imem_rvalid. If drop_q=0, push {inflight_pc, imem_rdata} to the FIFO. If drop_q=1, discard the data and clear drop_q.
- Credit check guarantees a response never finds the FIFO full. Overflow is an assertion failure.
- Redirect (highest priority over sequential PC):
  - pc_q <= redirect_addr.
  - FIFO flushed (out_valid=0 next cycle).
  - If in S_WAIT, or if a grant occurs in this same cycle, set drop_q=1 so that response is discarded.
  - No request is issued in the redirect cycle (imem_req forced 0). The first request to redirect_addr appears in the next cycle.
- Redirect in the same cycle as imem_rvalid: the response is dropped, not pushed, and drop_q stays 0.
- Redirect in the same cycle as out_valid&&out_ready: the pop completes and the flush still empties the FIFO.
- FIFO:
  - First-word fall-through; out_valid = !empty.
  - Pop on out_valid&&out_ready.
  - Simultaneous push and pop allowed at any fill level, including full-with-pop.
- Latency: a response accepted in cycle N is visible at the outputs in cycle N+1. Best-case throughput is one instruction per 2 cycles (req+gnt, rvalid).
- imem_addr = pc_q at all times.
- rst mid-operation: all state cleared in the same edge. A late response after reset is ignored because state=S_REQ and imem_rvalid is ignored outside S_WAIT.

Decomposition:
- Package fetch_pkg:
  - State enum {S_REQ, S_WAIT}.
  - PC_INC=4.
  - Fetch entry struct {pc, instr}.
- Sub-module fetch_fifo: parameterized sync FIFO with flush, push, pop, count, full and empty.

Test Plan:
- Reset then imem_gnt=1 every cycle, rvalid 1 cycle after grant, out_ready=1 -> imem_addr sequence 00,04,08,...; out_pc matches; out_instr equals data returned for each address.
- out_ready=0 with continuous grants -> exactly 2 entries buffered (out_pc 00 then 04 held), imem_req deasserts; raising out_ready resumes requests at 08.
- Start PC at FC -> next request address 00 (wrap), out_pc shows FC then 00.
- Redirect to 40 while in S_WAIT for address 08 -> response for 08 discarded; FIFO flushed; next imem_addr=40; first out_pc=40.
- Redirect to 80 in the same cycle as imem_rvalid -> that data never appears; next request at 80; drop_q remains 0, so the response for 80 is delivered.
- Assert rst while in S_WAIT with 1 entry buffered -> next cycle out_valid=0, imem_addr=00, state S_REQ; a stale imem_rvalid one cycle later produces no output.
